// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width, NOP encoding, next-PC select codes.
// Also used by pc_control, so encodings here must stay stable.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JAL    = 2'b10;
  localparam logic [1:0] PC_SEL_JALR   = 2'b11;

  function automatic logic is_redirect(input logic [1:0] sel);
    return sel != PC_SEL_PLUS4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus plus the IF/EXE register outputs of the fetch stage.
// master = fetch stage, slave = memory / downstream EXE stage.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            if_valid;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output if_pc,
    output if_instr,
    output if_valid
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  if_pc,
    input  if_instr,
    input  if_valid
  );

endinterface

// File: rtl/next_pc_sel.sv
// Next-PC selection: PC+4 (mod 2^32) or one of the EXE-stage redirect targets.
// Latency: purely combinational. Backpressure: none; stall is handled by the caller.
// Jalr target arrives as rs1+imm, so bit 0 is cleared here before anyone sees it.
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_mux_select,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jal_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic [XLEN-1:0] pc_plus4,
  output logic            redirect,
  output logic [XLEN-1:0] target
);

  assign pc_plus4 = pc + 32'd4;
  assign redirect = is_redirect(pc_mux_select);

  always_comb begin
    target = pc_plus4;
    case (pc_mux_select)
      PC_SEL_BRANCH: target = branch_target;
      PC_SEL_JAL:    target = jal_target;
      PC_SEL_JALR:   target = {jalr_target[XLEN-1:1], 1'b0};
      default:       target = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, IF/EXE pipeline register and RUN/HALT FSM.
// Latency: imem_addr follows PC combinationally; fetched word lands in IF/EXE one edge later.
// Backpressure: stall holds PC and IF/EXE; redirects override stall. MISALIGN_TRAP_EN enables the trap.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pc_mux_select,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jal_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            stall,
  output logic            misalign_fault,
  fetch_stage_if.master   fb
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic [XLEN-1:0] if_pc_q;
  logic [XLEN-1:0] if_instr_q;
  logic            if_valid_q;

  next_pc_sel u_next_pc_sel (
    .pc            (pc),
    .pc_mux_select (pc_mux_select),
    .branch_target (branch_target),
    .jal_target    (jal_target),
    .jalr_target   (jalr_target),
    .pc_plus4      (pc_plus4),
    .redirect      (redirect),
    .target        (target)
  );

  assign fb.imem_addr = pc;
  assign fb.if_pc     = if_pc_q;
  assign fb.if_instr  = if_instr_q;
  assign fb.if_valid  = if_valid_q;

`ifdef MISALIGN_TRAP_EN
  logic fault_q;
  logic target_misaligned;

  assign target_misaligned = target[1:0] != 2'b00;
  assign misalign_fault    = fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= NOP;
      if_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      state      <= ST_RUN;
    end else if (state == ST_HALT) begin
      // Parked until reset: PC frozen, bubbles only.
      if_instr_q <= NOP;
      if_valid_q <= 1'b0;
    end else if (redirect) begin
      if_pc_q    <= pc;
      if_instr_q <= NOP;
      if_valid_q <= 1'b0;
      if (target_misaligned) begin
        fault_q <= 1'b1;
        state   <= ST_HALT;
      end else begin
        pc <= target;
      end
    end else if (!stall) begin
      pc         <= pc_plus4;
      if_pc_q    <= pc;
      if_instr_q <= fb.imem_rdata;
      if_valid_q <= 1'b1;
    end
  end
`else
  assign misalign_fault = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= NOP;
      if_valid_q <= 1'b0;
      state      <= ST_RUN;
    end else if (state == ST_HALT) begin
      if_instr_q <= NOP;
      if_valid_q <= 1'b0;
    end else if (redirect) begin
      // Without the trap, targets are silently word-aligned.
      pc         <= target & ~32'h3;
      if_pc_q    <= pc;
      if_instr_q <= NOP;
      if_valid_q <= 1'b0;
    end else if (!stall) begin
      pc         <= pc_plus4;
      if_pc_q    <= pc;
      if_instr_q <= fb.imem_rdata;
      if_valid_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage (RESET_PC=0x100); memory returns addr+0x1000_0000.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_mux_select;
  logic [31:0] branch_target;
  logic [31:0] jal_target;
  logic [31:0] jalr_target;
  logic        stall;
  logic        misalign_fault;
  int          passed = 0;
  int          total  = 0;

  fetch_stage_if fb ();

  assign fb.imem_rdata = fb.imem_addr + 32'h1000_0000;

  fetch_stage #(.RESET_PC(32'h100)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_mux_select  (pc_mux_select),
    .branch_target  (branch_target),
    .jal_target     (jal_target),
    .jalr_target    (jalr_target),
    .stall          (stall),
    .misalign_fault (misalign_fault),
    .fb             (fb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; pc_mux_select = PC_SEL_PLUS4;
    branch_target = '0; jal_target = '0; jalr_target = '0;
    tick(); tick();
    rst = 1'b0;
    total++; if (fb.imem_addr !== 32'h100) $display("FAIL reset_addr got=%h exp=%h", fb.imem_addr, 32'h100); else passed++;
    total++; if (fb.if_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", fb.if_valid); else passed++;
    total++; if (fb.if_pc !== 32'h0) $display("FAIL reset_if_pc got=%h exp=0", fb.if_pc); else passed++;
    total++; if (fb.if_instr !== 32'h0000_0013) $display("FAIL reset_instr got=%h exp=00000013", fb.if_instr); else passed++;
    total++; if (misalign_fault !== 1'b0) $display("FAIL reset_fault got=%b exp=0", misalign_fault); else passed++;
    tick();
    total++; if (fb.if_pc !== 32'h100) $display("FAIL first_if_pc got=%h exp=100", fb.if_pc); else passed++;
    total++; if (fb.if_valid !== 1'b1) $display("FAIL first_valid got=%b exp=1", fb.if_valid); else passed++;
    total++; if (fb.if_instr !== 32'h1000_0100) $display("FAIL first_instr got=%h exp=10000100", fb.if_instr); else passed++;
    total++; if (fb.imem_addr !== 32'h104) $display("FAIL first_addr got=%h exp=104", fb.imem_addr); else passed++;
    tick();
    total++; if (fb.imem_addr !== 32'h108) $display("FAIL seq_addr got=%h exp=108", fb.imem_addr); else passed++;
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (fb.imem_addr !== 32'h108) $display("FAIL stall_addr[%0d] got=%h exp=108", i, fb.imem_addr); else passed++;
      total++; if (fb.if_pc !== 32'h104) $display("FAIL stall_if_pc[%0d] got=%h exp=104", i, fb.if_pc); else passed++;
      total++; if (fb.if_instr !== 32'h1000_0104) $display("FAIL stall_instr[%0d] got=%h exp=10000104", i, fb.if_instr); else passed++;
    end
    stall = 1'b0;
    tick();
    total++; if (fb.if_pc !== 32'h108) $display("FAIL release_if_pc got=%h exp=108", fb.if_pc); else passed++;
    total++; if (fb.if_instr !== 32'h1000_0108) $display("FAIL release_instr got=%h exp=10000108", fb.if_instr); else passed++;
    total++; if (fb.imem_addr !== 32'h10C) $display("FAIL release_addr got=%h exp=10c", fb.imem_addr); else passed++;
  endtask

  task automatic test_branch();
    pc_mux_select = PC_SEL_BRANCH; branch_target = 32'h200;
    tick();
    pc_mux_select = PC_SEL_PLUS4;
    total++; if (fb.imem_addr !== 32'h200) $display("FAIL branch_addr got=%h exp=200", fb.imem_addr); else passed++;
    total++; if (fb.if_valid !== 1'b0) $display("FAIL branch_valid got=%b exp=0", fb.if_valid); else passed++;
    total++; if (fb.if_instr !== 32'h0000_0013) $display("FAIL branch_instr got=%h exp=00000013", fb.if_instr); else passed++;
    total++; if (fb.if_pc !== 32'h10C) $display("FAIL branch_flush_pc got=%h exp=10c", fb.if_pc); else passed++;
    tick();
    total++; if (fb.if_pc !== 32'h200) $display("FAIL branch_if_pc got=%h exp=200", fb.if_pc); else passed++;
    total++; if (fb.if_valid !== 1'b1) $display("FAIL branch_next_valid got=%b exp=1", fb.if_valid); else passed++;
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; pc_mux_select = PC_SEL_JALR; jalr_target = 32'h301;
    tick();
    pc_mux_select = PC_SEL_PLUS4;
    total++; if (fb.imem_addr !== 32'h300) $display("FAIL jalr_stall_addr got=%h exp=300", fb.imem_addr); else passed++;
    total++; if (fb.if_valid !== 1'b0) $display("FAIL jalr_stall_valid got=%b exp=0", fb.if_valid); else passed++;
    tick();
    total++; if (fb.imem_addr !== 32'h300) $display("FAIL jalr_hold_addr got=%h exp=300", fb.imem_addr); else passed++;
    stall = 1'b0;
    tick();
    total++; if (fb.if_pc !== 32'h300 || fb.if_valid !== 1'b1)
      $display("FAIL jalr_resume got=%h/%b exp=300/1", fb.if_pc, fb.if_valid); else passed++;
  endtask

  task automatic test_wrap();
    pc_mux_select = PC_SEL_JALR; jalr_target = 32'hFFFF_FFFC;
    tick();
    pc_mux_select = PC_SEL_PLUS4;
    total++; if (fb.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_setup got=%h exp=fffffffc", fb.imem_addr); else passed++;
    tick();
    total++; if (fb.imem_addr !== 32'h0) $display("FAIL wrap_addr got=%h exp=0", fb.imem_addr); else passed++;
    total++; if (fb.if_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_if_pc got=%h exp=fffffffc", fb.if_pc); else passed++;
  endtask

  task automatic test_rst_priority();
    rst = 1'b1; stall = 1'b1; pc_mux_select = PC_SEL_BRANCH; branch_target = 32'h500;
    tick();
    rst = 1'b0; stall = 1'b0; pc_mux_select = PC_SEL_PLUS4;
    total++; if (fb.imem_addr !== 32'h100) $display("FAIL rstprio_addr got=%h exp=100", fb.imem_addr); else passed++;
    total++; if (fb.if_valid !== 1'b0) $display("FAIL rstprio_valid got=%b exp=0", fb.if_valid); else passed++;
  endtask

  task automatic test_misalign();
    pc_mux_select = PC_SEL_JAL; jal_target = 32'h402;
    tick();
    pc_mux_select = PC_SEL_PLUS4;
`ifdef MISALIGN_TRAP_EN
    total++; if (misalign_fault !== 1'b1) $display("FAIL trap_fault got=%b exp=1", misalign_fault); else passed++;
    total++; if (fb.imem_addr !== 32'h100) $display("FAIL trap_pc_hold got=%h exp=100", fb.imem_addr); else passed++;
    total++; if (fb.if_valid !== 1'b0) $display("FAIL trap_valid got=%b exp=0", fb.if_valid); else passed++;
    tick();
    pc_mux_select = PC_SEL_BRANCH; branch_target = 32'h200;
    tick();
    pc_mux_select = PC_SEL_PLUS4;
    total++; if (fb.imem_addr !== 32'h100) $display("FAIL halt_addr got=%h exp=100", fb.imem_addr); else passed++;
    total++; if (fb.if_valid !== 1'b0 || fb.if_instr !== 32'h0000_0013)
      $display("FAIL halt_ifexe got=%b/%h exp=0/00000013", fb.if_valid, fb.if_instr); else passed++;
    total++; if (misalign_fault !== 1'b1) $display("FAIL halt_fault got=%b exp=1", misalign_fault); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (misalign_fault !== 1'b0) $display("FAIL trap_rst_fault got=%b exp=0", misalign_fault); else passed++;
    tick();
    total++; if (fb.if_valid !== 1'b1 || fb.if_pc !== 32'h100)
      $display("FAIL trap_rst_run got=%b/%h exp=1/100", fb.if_valid, fb.if_pc); else passed++;
`else
    total++; if (fb.imem_addr !== 32'h400) $display("FAIL noalign_addr got=%h exp=400", fb.imem_addr); else passed++;
    total++; if (misalign_fault !== 1'b0) $display("FAIL noalign_fault got=%b exp=0", misalign_fault); else passed++;
    tick();
    total++; if (fb.if_pc !== 32'h400 || fb.if_valid !== 1'b1)
      $display("FAIL noalign_run got=%h/%b exp=400/1", fb.if_pc, fb.if_valid); else passed++;
    pc_mux_select = PC_SEL_BRANCH; branch_target = 32'h603;
    tick();
    pc_mux_select = PC_SEL_PLUS4;
    total++; if (fb.imem_addr !== 32'h600) $display("FAIL noalign_branch got=%h exp=600", fb.imem_addr); else passed++;
    total++; if (misalign_fault !== 1'b0) $display("FAIL noalign_fault2 got=%b exp=0", misalign_fault); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_redirect_stall();
    test_wrap();
    test_rst_priority();
    test_misalign();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
